// File: rtl/mult_sweep_checker_if.sv
// Operand/product bus between the sweep checker and the multiplier under test.
interface mult_sweep_checker_if #(
    parameter int unsigned WIDTH = 2
);
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [2*WIDTH-1:0] prod;

    modport master (output op_a, output op_b, input prod);
    modport slave  (input op_a, input op_b, output prod);
endinterface

// File: rtl/mult_sweep_checker.sv
// Exhaustive operand sweep for a combinational multiplier: drives every A/B pair, waits a settle
// time, checks P against the exact product and reports error count and the first failing vector.
module mult_sweep_checker #(
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    mult_sweep_checker_if.master  mul,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2*WIDTH:0]      err_count,
    output logic [2*WIDTH:0]      vec_count,
    output logic [WIDTH-1:0]      fail_a,
    output logic [WIDTH-1:0]      fail_b,
    output logic [2*WIDTH-1:0]    fail_p
);
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  op_a_q, op_b_q;
    logic [CW-1:0]     err_q, vec_q;
    logic [WIDTH-1:0]  fa_q, fb_q;
    logic [PW-1:0]     fp_q;

    logic [PW-1:0]     golden;
    logic              mismatch;
    logic              last_pair;

    assign golden    = PW'(op_a_q) * PW'(op_b_q);
    assign mismatch  = (mul.prod != golden);
    assign last_pair = (&op_a_q) && (&op_b_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StSettle;
            StSettle: if (cnt_q == '0) state_d = StCheck;
            StCheck:  state_d = last_pair ? StDone : StSettle;
            StDone:   if (start) state_d = StSettle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StSettle) || (state_q == StCheck);
        done = (state_q == StDone);
        pass = done && (err_q == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            op_a_q <= '0;
            op_b_q <= '0;
            err_q  <= '0;
            vec_q  <= '0;
            fa_q   <= '0;
            fb_q   <= '0;
            fp_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    // Restart clears all results in the same edge that accepts start.
                    if (start) begin
                        cnt_q  <= CntLoad;
                        op_a_q <= '0;
                        op_b_q <= '0;
                        err_q  <= '0;
                        vec_q  <= '0;
                        fa_q   <= '0;
                        fb_q   <= '0;
                        fp_q   <= '0;
                    end
                end
                StSettle: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - CntW'(1);
                end
                StCheck: begin
                    vec_q <= vec_q + CW'(1);
                    if (mismatch) begin
                        err_q <= err_q + CW'(1);
                        if (err_q == '0) begin
                            fa_q <= op_a_q;
                            fb_q <= op_b_q;
                            fp_q <= mul.prod;
                        end
                    end
                    if (!last_pair) begin
                        cnt_q <= CntLoad;
                        if (&op_b_q) begin
                            op_b_q <= '0;
                            op_a_q <= op_a_q + WIDTH'(1);
                        end else begin
                            op_b_q <= op_b_q + WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mul.op_a  = op_a_q;
    assign mul.op_b  = op_b_q;
    assign err_count = err_q;
    assign vec_count = vec_q;
    assign fail_a    = fa_q;
    assign fail_b    = fb_q;
    assign fail_p    = fp_q;
endmodule

// File: tb/tb_mult_sweep_checker.sv
// Bench for mult_sweep_checker: a behavioural multiplier with injectable faults feeds two DUTs
// (defaults and WIDTH=3/SETTLE=2); results are compared against an enumerated reference sweep.
module tb_mult_sweep_checker;
    logic clk = 1'b0;
    logic rst_n;
    logic start0, start1;

    always #5 clk = ~clk;

    mult_sweep_checker_if #(.WIDTH(2)) bus0 ();
    mult_sweep_checker_if #(.WIDTH(3)) bus1 ();

    logic       busy0, done0, pass0;
    logic [4:0] err0, vec0;
    logic [1:0] fa0, fb0;
    logic [3:0] fp0;
    logic       busy1, done1, pass1;
    logic [6:0] err1, vec1;
    logic [2:0] fa1, fb1;
    logic [5:0] fp1;

    mult_sweep_checker #(.WIDTH(2), .SETTLE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .mul(bus0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .vec_count(vec0),
        .fail_a(fa0), .fail_b(fb0), .fail_p(fp0)
    );

    mult_sweep_checker #(.WIDTH(3), .SETTLE(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mul(bus1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .vec_count(vec1),
        .fail_a(fa1), .fail_b(fb1), .fail_p(fp1)
    );

    // Fault modes: 0 exact, 1 P[0] stuck at 0, 2 one chosen pair returns a chosen value.
    int unsigned md [2];
    logic [63:0] f_a [2], f_b [2], f_v [2];

    function automatic logic [63:0] mul_ref(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned mode, input logic [63:0] fa,
                                            input logic [63:0] fb, input logic [63:0] fv);
        logic [63:0] p;
        p = a * b;
        if (mode == 1) p = p & ~64'd1;
        if (mode == 2 && a == fa && b == fb) p = fv;
        return p;
    endfunction

    always_comb bus0.prod = 4'(mul_ref(64'(bus0.op_a), 64'(bus0.op_b), md[0], f_a[0], f_b[0], f_v[0]));
    always_comb bus1.prod = 6'(mul_ref(64'(bus1.op_a), 64'(bus1.op_b), md[1], f_a[1], f_b[1], f_v[1]));

    int errors = 0;
    int checks = 0;
    logic [63:0] s_a, s_b, s_err, s_vec, s_fa, s_fb, s_fp;
    logic s_busy, s_done, s_pass;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input int sel);
        if (sel == 0) begin
            s_a = 64'(bus0.op_a); s_b = 64'(bus0.op_b); s_err = 64'(err0); s_vec = 64'(vec0);
            s_fa = 64'(fa0); s_fb = 64'(fb0); s_fp = 64'(fp0);
            s_busy = busy0; s_done = done0; s_pass = pass0;
        end else begin
            s_a = 64'(bus1.op_a); s_b = 64'(bus1.op_b); s_err = 64'(err1); s_vec = 64'(vec1);
            s_fa = 64'(fa1); s_fb = 64'(fb1); s_fp = 64'(fp1);
            s_busy = busy1; s_done = done1; s_pass = pass1;
        end
    endtask

    task automatic check_idle(input int sel, input string tag);
        sample(sel);
        chk({tag, "_busy"}, 64'(s_busy), 0);
        chk({tag, "_done"}, 64'(s_done), 0);
        chk({tag, "_pass"}, 64'(s_pass), 0);
        chk({tag, "_ops"}, {s_a[31:0], s_b[31:0]}, 0);
        chk({tag, "_counts"}, {s_err[31:0], s_vec[31:0]}, 0);
        chk({tag, "_fail"}, s_fa | s_fb | s_fp, 0);
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v; else start1 = v;
    endtask

    // One full sweep from a start pulse; checks the pair sequence every cycle and the final report.
    task automatic run_sweep(input int sel, input bit hold, input string tag);
        int unsigned w, s, n, maxv, e, k, exp_err;
        logic [63:0] p, exp_fa, exp_fb, exp_fp;
        w = (sel == 0) ? 2 : 3;
        s = (sel == 0) ? 1 : 2;
        n = 1 << (2 * w);
        maxv = (1 << w) - 1;
        exp_err = 0; exp_fa = 0; exp_fb = 0; exp_fp = 0;
        for (int a = 0; a <= int'(maxv); a++) begin
            for (int b = 0; b <= int'(maxv); b++) begin
                p = mul_ref(64'(a), 64'(b), md[sel], f_a[sel], f_b[sel], f_v[sel]);
                if (p != 64'(a * b)) begin
                    if (exp_err == 0) begin
                        exp_fa = 64'(a); exp_fb = 64'(b); exp_fp = p;
                    end
                    exp_err++;
                end
            end
        end
        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) set_start(sel, 1'b0);
        e = 0;
        while (1) begin
            sample(sel);
            if (s_done === 1'b1 || e >= n * (s + 1) + 4) break;
            k = e / (s + 1);
            chk({tag, "_pair"}, (s_a << w) | s_b, 64'(k));
            chk({tag, "_busy"}, 64'(s_busy), 1);
            chk({tag, "_pass_early"}, 64'(s_pass), 0);
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        chk({tag, "_done_edge"}, 64'(e), 64'(n * (s + 1)));
        chk({tag, "_done"}, 64'(s_done), 1);
        chk({tag, "_busy_done"}, 64'(s_busy), 0);
        chk({tag, "_vec"}, s_vec, 64'(n));
        chk({tag, "_err"}, s_err, 64'(exp_err));
        chk({tag, "_pass"}, 64'(s_pass), (exp_err == 0) ? 64'd1 : 64'd0);
        chk({tag, "_fail_a"}, s_fa, exp_fa);
        chk({tag, "_fail_b"}, s_fb, exp_fb);
        chk({tag, "_fail_p"}, s_fp, exp_fp);
        chk({tag, "_last_pair"}, {s_a[31:0], s_b[31:0]}, {32'(maxv), 32'(maxv)});
    endtask

    initial begin
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            md[i] = 0; f_a[i] = 0; f_b[i] = 0; f_v[i] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle(0, "reset0");
        check_idle(1, "reset1");
        rst_n = 1'b1;

        run_sweep(0, 1'b0, "exact");

        md[0] = 1;
        run_sweep(0, 1'b0, "stuck0");
        chk("stuck0_err_const", s_err, 4);
        chk("stuck0_fail_const", {s_fa[15:0], s_fb[15:0], s_fp[15:0]}, {16'd1, 16'd1, 16'd0});

        md[0] = 2; f_a[0] = 2; f_b[0] = 3; f_v[0] = 0;
        run_sweep(0, 1'b0, "pair23");
        chk("pair23_err_const", s_err, 1);

        for (int r = 0; r < 3; r++) begin
            f_a[0] = 64'($urandom_range(0, 3));
            f_b[0] = 64'($urandom_range(0, 3));
            f_v[0] = (f_a[0] * f_b[0] + 64'($urandom_range(1, 15))) % 16;
            run_sweep(0, 1'b0, $sformatf("rand%0d", r));
        end

        md[0] = 0;
        run_sweep(0, 1'b1, "hold");
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        sample(0);
        chk("restart_done", 64'(s_done), 0);
        chk("restart_busy", 64'(s_busy), 1);
        chk("restart_counts", {s_err[31:0], s_vec[31:0]}, 0);
        chk("restart_ops", {s_a[31:0], s_b[31:0]}, 0);

        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_idle(0, "midreset");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_idle(0, "postreset");
        end
        run_sweep(0, 1'b0, "after_reset");

        run_sweep(1, 1'b0, "w3_exact");
        md[1] = 2;
        f_a[1] = 64'($urandom_range(0, 7));
        f_b[1] = 64'($urandom_range(0, 7));
        f_v[1] = (f_a[1] * f_b[1] + 64'($urandom_range(1, 63))) % 64;
        run_sweep(1, 1'b0, "w3_rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
